sfu: RTL and testbench
======================

// Module: sfu
// PURPOSE
//  Special function unit at the output of the 8x8 systolic array. Per-column
//  signed accumulation of partial sums over successive cycles while acc_i is
//  high. Drives the accumulated column results to the output buffer.
// PARAMETERS
//  bw       4   activation/weight bit width (carried for array consistency; unused in datapath)
//  col      8   number of array columns = independent accumulator lanes
//  row      8   number of array rows (carried for consistency; unused in datapath)
//  psum_bw  16  bit width of each partial sum and accumulator lane
// PORTS
//  clk       in   1            single clock; all state on rising edge
//  reset     in   1            asynchronous, active-low reset
//  acc_i     in   1            accumulate enable for all lanes
//  psum_in   in   psum_bw*col  packed psums; lane c = [psum_bw*(c+1)-1 : psum_bw*c], two's complement
//  psum_out  out  psum_bw*col  packed registered lane results, same packing
// BEHAVIOUR
//  - reset low: all accumulators, psum_out and the internal acc_d flag clear to 0 immediately, async; a
//    mid-accumulation reset discards the partial result.
//  - acc_d: registered copy of acc_i from the previous cycle.
//  - Per lane, at each rising edge with reset high:
//    acc_i=1, acc_d=0 (first beat of a burst): acc <= psum_in lane (restart).
//    acc_i=1, acc_d=1: acc <= sat(acc + psum_in lane).
//    acc_i=0: acc holds; psum_in ignored.
//  - Arithmetic: signed psum_bw+1-bit sum, saturated to [-2^(psum_bw-1), 2^(psum_bw-1)-1]
//    (16b: 0x8000..0x7FFF); no wrap-around.
//  - psum_out = acc register directly (no extra stage); a sample taken at edge N is visible
//    after edge N; latency 1 cycle.
//  - Lanes fully independent; saturation in one lane never affects another.
//  - No handshake/backpressure; a new psum is accepted every cycle acc_i is high.
// CONFIGURATION
//  SFU_RELU_EN defined: psum_out lane = (acc < 0) ? 0 : acc; ReLU is combinational on the
//    output only; the stored acc keeps its signed value so accumulation is unaffected.
//  SFU_RELU_EN undefined: psum_out lane = acc, signed value passed through.
// STRUCTURE
//  - Package sfu_pkg: default PSUM_BW/COL constants, SAT_MAX/SAT_MIN, signed lane typedef
//    psum_t, function sat_add(psum_t a, psum_t b).
//  - Sub-module sfu_lane (one accumulator + saturation + optional ReLU), generated col times;
//    top holds acc_d and the lane slicing.
// TESTING
//  1 reset low at t=0, any inputs -> psum_out all 0; release, acc_i=0 -> stays 0.
//  2 lane0 psum=0x0005 with acc_i=1 for 3 cycles -> 0x0005, 0x000A, 0x000F; then acc_i=0,
//    psum=0x1234 -> holds 0x000F.
//  3 after a hold, acc_i=1, psum=0x0003 -> lane0 restarts at 0x0003 (not 0x0012).
//  4 lane1 0x7000 then 0x7000 -> 0x7FFF; lane2 0x9000 then 0x9000 -> 0x8000; other lanes
//    unaffected.
//  5 SFU_RELU_EN: lane3 0xFFFE, 0xFFFF -> out 0x0000; then +0x0005 -> 0x0002 (internal acc -3+5).
//  6 reset low mid-burst (acc=0x000A) -> psum_out 0 at once, before next clk edge; after release,
//    first acc_i=1 beat loads.

Source files
------------

// File: rtl/sfu_pkg.sv
// sfu_pkg: shared lane width, saturation limits and saturating adder for the SFU
package sfu_pkg;
  localparam int PSUM_BW = 16;
  localparam int COL = 8;
  typedef logic signed [PSUM_BW-1:0] psum_t;
  localparam psum_t SAT_MAX = psum_t'({1'b0, {(PSUM_BW-1){1'b1}}});
  localparam psum_t SAT_MIN = psum_t'({1'b1, {(PSUM_BW-1){1'b0}}});
  // One guard bit catches overflow: the top two sum bits disagree only when the result left the lane range.
  function automatic psum_t sat_add(psum_t a, psum_t b);
    logic signed [PSUM_BW:0] s;
    s = {a[PSUM_BW-1], a} + {b[PSUM_BW-1], b};
    return (s[PSUM_BW] != s[PSUM_BW-1]) ? (s[PSUM_BW] ? SAT_MIN : SAT_MAX) : s[PSUM_BW-1:0];
  endfunction
endpackage

// File: rtl/sfu_lane.sv
// sfu_lane: one saturating signed accumulator lane with optional output ReLU
//   clk, reset (async, active-low), acc_i (accumulate enable), acc_d_i (acc_i of the previous cycle),
//   psum_i (signed partial sum), psum_o (registered lane result).
//   SFU_RELU_EN: clamps negative results to zero on the output only.
module sfu_lane
  import sfu_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  acc_i,
  input  logic  acc_d_i,
  input  psum_t psum_i,
  output psum_t psum_o
);
  psum_t acc_q, acc_d;
  // The first beat of a burst restarts the lane instead of adding to the stale result.
  always_comb acc_d = acc_i ? (acc_d_i ? sat_add(acc_q, psum_i) : psum_i) : acc_q;
  always_ff @(posedge clk or negedge reset)
    if (!reset) acc_q <= '0;
    else acc_q <= acc_d;
`ifdef SFU_RELU_EN
  // The stored value stays signed so later beats still see the true running sum.
  assign psum_o = acc_q[PSUM_BW-1] ? '0 : acc_q;
`else
  assign psum_o = acc_q;
`endif
endmodule

// File: rtl/sfu.sv
// sfu: per-column saturating accumulator bank at the systolic array output
//   clk, reset (async, active-low), acc_i (accumulate enable, all lanes),
//   psum_in (col packed signed psums), psum_out (col packed registered results).
//   SFU_RELU_EN: optional ReLU on each lane output.
module sfu
  import sfu_pkg::*;
#(
  parameter int bw      = 4,
  parameter int col     = COL,
  parameter int row     = 8,
  parameter int psum_bw = PSUM_BW
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   acc_i,
  input  logic [psum_bw*col-1:0] psum_in,
  output logic [psum_bw*col-1:0] psum_out
);
  logic acc_d_q, acc_d_d;
  always_comb acc_d_d = acc_i;
  always_ff @(posedge clk or negedge reset)
    if (!reset) acc_d_q <= 1'b0;
    else acc_d_q <= acc_d_d;
  // An array with no rows or no activation bits produces nothing to accumulate.
  if (bw > 0 && row > 0) begin : g_arr
    for (genvar c = 0; c < col; c++) begin : g_lane
      sfu_lane u_lane (
        .clk    (clk),
        .reset  (reset),
        .acc_i  (acc_i),
        .acc_d_i(acc_d_q),
        .psum_i (psum_in[psum_bw*c +: psum_bw]),
        .psum_o (psum_out[psum_bw*c +: psum_bw])
      );
    end
  end else begin : g_none
    assign psum_out = '0;
  end
endmodule

// File: tb/tb_sfu.sv
// tb_sfu: directed scoreboard bench for the sfu accumulator bank
module tb_sfu;
  typedef struct {
    string        nm;
    logic [127:0] exp;
  } exp_t;
  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         acc_i = 1'b0;
  logic [127:0] psum_in = '0;
  logic [127:0] psum_out;
  exp_t         q[$];
  event         async_ev;
  int           n_vec = 0;
  int           n_err = 0;
`ifdef SFU_RELU_EN
  localparam logic [15:0] L3A = 16'h0000, L3B = 16'h0000, L3C = 16'h0002;
`else
  localparam logic [15:0] L3A = 16'hFFFE, L3B = 16'hFFFD, L3C = 16'h0002;
`endif
  sfu dut (
    .clk     (clk),
    .reset   (reset),
    .acc_i   (acc_i),
    .psum_in (psum_in),
    .psum_out(psum_out)
  );
  always #5 clk = ~clk;
  function automatic logic [127:0] ln(input logic [15:0] l0, l1, l2, l3);
    return {64'h0, l3, l2, l1, l0};
  endfunction
  task automatic step(input logic a, input logic [127:0] p, input logic [127:0] e, input string nm);
    @(negedge clk);
    acc_i = a;
    psum_in = p;
    q.push_back('{nm, e});
  endtask
  initial begin
    exp_t e;
    forever begin
      @(posedge clk or async_ev);
      #1;
      while (q.size() > 0) begin
        e = q.pop_front();
        n_vec++;
        if (psum_out !== e.exp) begin
          n_err++;
          $display("FAIL %s: psum_out=%h expected=%h", e.nm, psum_out, e.exp);
        end
      end
    end
  end
  initial begin
    #2;
    q.push_back('{"reset_t0", 128'h0});
    ->async_ev;
    step(1'b1, ln(16'h0005, 0, 0, 0), 128'h0, "acc_in_reset");
    step(1'b0, ln(16'h1234, 0, 0, 0), 128'h0, "idle_after_reset");
    reset = 1'b1;
    step(1'b1, ln(16'h0005, 0, 0, 0), ln(16'h0005, 0, 0, 0), "acc_beat1");
    step(1'b1, ln(16'h0005, 0, 0, 0), ln(16'h000A, 0, 0, 0), "acc_beat2");
    step(1'b1, ln(16'h0005, 0, 0, 0), ln(16'h000F, 0, 0, 0), "acc_beat3");
    step(1'b0, ln(16'h1234, 0, 0, 0), ln(16'h000F, 0, 0, 0), "hold");
    step(1'b1, ln(16'h0003, 0, 0, 0), ln(16'h0003, 0, 0, 0), "restart");
    step(1'b1, ln(0, 16'h7000, 16'h9000, 0), ln(16'h0003, 16'h7000, 16'h9000, 0), "sat_beat1");
    step(1'b1, ln(0, 16'h7000, 16'h9000, 0), ln(16'h0003, 16'h7FFF, 16'h8000, 0), "sat_clip");
    step(1'b1, ln(0, 16'h0001, 16'hFFFF, 0), ln(16'h0003, 16'h7FFF, 16'h8000, 0), "sat_stick");
    step(1'b1, ln(0, 16'hFFFF, 16'h0001, 0), ln(16'h0003, 16'h7FFE, 16'h8001, 0), "sat_unwind");
    step(1'b0, ln(0, 0, 0, 16'h4444), ln(16'h0003, 16'h7FFE, 16'h8001, 0), "hold2");
    step(1'b1, ln(0, 0, 0, 16'hFFFE), ln(0, 0, 0, L3A), "neg_beat1");
    step(1'b1, ln(0, 0, 0, 16'hFFFF), ln(0, 0, 0, L3B), "neg_beat2");
    step(1'b1, ln(0, 0, 0, 16'h0005), ln(0, 0, 0, L3C), "neg_recover");
    step(1'b0, 128'h0, ln(0, 0, 0, L3C), "hold3");
    step(1'b1, ln(16'h0005, 0, 0, 0), ln(16'h0005, 0, 0, 0), "burst_beat1");
    step(1'b1, ln(16'h0005, 0, 0, 0), ln(16'h000A, 0, 0, 0), "burst_beat2");
    @(negedge clk);
    #2;
    reset = 1'b0;
    acc_i = 1'b0;
    q.push_back('{"async_reset", 128'h0});
    ->async_ev;
    step(1'b1, ln(16'h0009, 0, 0, 0), 128'h0, "held_in_reset");
    step(1'b0, ln(16'h0009, 0, 0, 0), 128'h0, "post_reset_idle");
    reset = 1'b1;
    step(1'b1, ln(16'h0007, 0, 0, 0), ln(16'h0007, 0, 0, 0), "reload");
    step(1'b1, ln(16'h0007, 0, 0, 0), ln(16'h000E, 0, 0, 0), "reload_acc");
    step(1'b0, 128'h0, ln(16'h000E, 0, 0, 0), "final_hold");
    @(negedge clk);
    @(negedge clk);
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
